// File: rtl/vdq_circle_limiter_if.sv
// Request/result bundle between the d/q PI controllers, the circle limiter and
// the inverse Park stage.
interface vdq_circle_limiter_if;
  logic               i_en;
  logic        [14:0] i_vmax;
  logic signed [15:0] i_vd;
  logic signed [15:0] i_vq;
  logic               o_busy;
  logic               o_en;
  logic signed [15:0] o_vd;
  logic signed [15:0] o_vq;
  logic               o_limited;

  modport master (
    output i_en, i_vmax, i_vd, i_vq,
    input  o_busy, o_en, o_vd, o_vq, o_limited
  );

  modport slave (
    input  i_en, i_vmax, i_vd, i_vq,
    output o_busy, o_en, o_vd, o_vq, o_limited
  );
endinterface

// File: rtl/vdq_circle_limiter.sv
// Limits a (Vd, Vq) request to a circle of radius Vmax, d-axis first; the
// remaining q headroom floor(sqrt(Vmax^2 - Vd^2)) comes from a bit-serial root.
//
// state | meaning
// IDLE  | waiting for i_en, outputs hold last result
// PREP  | clamp Vd, form radicand Vmax^2 - Vd_c^2
// SQRT  | 15 restoring root iterations, one result bit per cycle
// OUT   | clamp Vq to the root, register results, pulse o_en
module vdq_circle_limiter (
  input logic                 clk,
  input logic                 rstn,
  vdq_circle_limiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, PREP = 2'd1, SQRT = 2'd2, OUT = 2'd3} state_t;

  state_t             state_q, state_d;
  logic signed [15:0] vd_q, vq_q, vdc_q, ovd_q, ovq_q;
  logic        [14:0] vmax_q, root_q;
  logic        [29:0] rad_q;
  logic        [15:0] rem_q;
  logic        [3:0]  cnt_q;
  logic               en_q, lim_q;

  logic signed [15:0] vmax_s, vdc, qlim_s, vqc;
  logic        [14:0] vdc_mag;
  logic        [29:0] vmax_sq, vdc_sq, rem_init;
  logic        [17:0] rem_sh, trial;
  logic        [15:0] rem_nx;
  logic               take_bit;

  always_comb begin
    vmax_s   = {1'b0, vmax_q};
    vdc      = (vd_q > vmax_s) ? vmax_s : ((vd_q < -vmax_s) ? -vmax_s : vd_q);
    // |vdc| is at most 32767 here, so a 15-bit magnitude is exact
    vdc_mag  = vdc[15] ? (~vdc[14:0] + 15'd1) : vdc[14:0];
    vmax_sq  = {15'd0, vmax_q} * {15'd0, vmax_q};
    vdc_sq   = {15'd0, vdc_mag} * {15'd0, vdc_mag};
    rem_init = vmax_sq - vdc_sq;

    // remainder never exceeds twice the partial root, so 16 bits suffice
    rem_sh   = {rem_q, rad_q[29:28]};
    trial    = {1'b0, root_q, 2'b01};
    take_bit = (rem_sh >= trial);
    rem_nx   = take_bit ? (rem_sh[15:0] - trial[15:0]) : rem_sh[15:0];

    qlim_s   = {1'b0, root_q};
    vqc      = (vq_q > qlim_s) ? qlim_s : ((vq_q < -qlim_s) ? -qlim_s : vq_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_en) state_d = PREP;
      PREP:    state_d = SQRT;
      SQRT:    if (cnt_q == 4'd0) state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.o_busy    = (state_q != IDLE);
    bus.o_en      = en_q;
    bus.o_vd      = ovd_q;
    bus.o_vq      = ovq_q;
    bus.o_limited = lim_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vd_q   <= '0;
      vq_q   <= '0;
      vmax_q <= '0;
      vdc_q  <= '0;
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      ovd_q  <= '0;
      ovq_q  <= '0;
      lim_q  <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      en_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.i_en) begin
          vd_q   <= bus.i_vd;
          vq_q   <= bus.i_vq;
          vmax_q <= bus.i_vmax;
        end
        PREP: begin
          vdc_q  <= vdc;
          rad_q  <= rem_init;
          rem_q  <= '0;
          root_q <= '0;
          cnt_q  <= 4'd14;
        end
        SQRT: begin
          rem_q  <= rem_nx;
          root_q <= {root_q[13:0], take_bit};
          rad_q  <= {rad_q[27:0], 2'b00};
          cnt_q  <= cnt_q - 4'd1;
        end
        OUT: begin
          ovd_q <= vdc_q;
          ovq_q <= vqc;
          lim_q <= (vdc_q != vd_q) || (vqc != vq_q);
          en_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/vdq_circle_limiter.md
Name: vdq_circle_limiter

Overview:
- Sits directly downstream of the d-axis and q-axis PI controllers, and upstream of the inverse Park / SVPWM stage.
- Takes one (Vd, Vq) request pair and limits the voltage vector to a circle of radius Vmax.
- The d-axis has priority: Vd is clamped to ±Vmax first. Vq is then clamped to ±floor(sqrt(Vmax² − Vd²)).
- The square root is computed bit-serially with a multi-cycle FSM, one result per request.

Parameters:
- none (all widths fixed: 16-bit signed voltages, 15-bit unsigned limit)

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- i_en  input  1  one-cycle strobe: i_vd, i_vq, i_vmax are valid
- i_vmax  input  15  unsigned circle radius, 0..32767
- i_vd  input  16  signed d-axis voltage request (d-PI output)
- i_vq  input  16  signed q-axis voltage request (q-PI output)
- o_busy  output  1  high while a request is in progress (state ≠ IDLE)
- o_en  output  1  one-cycle strobe: o_vd, o_vq, o_limited are updated
- o_vd  output  16  signed limited d voltage, held between updates
- o_vq  output  16  signed limited q voltage, held between updates
- o_limited  output  1  1 if either axis was modified in the last result, held

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rstn.
- Reset values: state=IDLE; o_busy=0, o_en=0, o_vd=0, o_vq=0, o_limited=0; all internal registers 0.
- FSM states: IDLE, PREP, SQRT, OUT.
- IDLE: at an edge with i_en=1, register i_vd, i_vq, i_vmax and go to PREP. o_busy is 1 from the following cycle.
- PREP, one cycle:
  - vd_c = clamp(vd, −vmax, +vmax). vd = −32768 with vmax = 32767 gives −32767.
  - rem = vmax² − vd_c², 30-bit unsigned, always ≥ 0.
  - Clear the sqrt root and remainder, set iteration counter = 14. Go to SQRT.
- SQRT: restoring bit-serial integer square root, one result bit per cycle, MSB first, 15 cycles (counter 14 down to 0).
  - Result qlim = floor(sqrt(rem)), 15 bits, 0..32767.
  - After the counter-0 cycle, go to OUT.
- OUT, one cycle:
  - vq_c = clamp(vq, −qlim, +qlim).
  - Register o_vd=vd_c, o_vq=vq_c.
  - o_limited = (vd_c ≠ vd) | (vq_c ≠ vq).
  - Pulse o_en=1 for exactly one cycle. Go to IDLE.
- Latency: i_en sampled at edge N → outputs and o_en registered at edge N+17 (fixed 17 clocks). Throughput is one request per 18 clocks.
- i_en while o_busy=1 (edges N+1..N+17): ignored, with no effect on the computation in progress. The next accepted i_en is at edge N+18 or later. The upstream PI rate is far slower, so no queueing is required.
- Input sampling: inputs are sampled only at the accepting edge. Changes afterwards do not affect the result.
- All clamps are symmetric: the negative bound is −bound, never −bound−1.
- vmax = 0: result is (0, 0). o_limited=1 unless both inputs are 0.
- Outputs hold their last values while IDLE. o_en=0 except in the OUT cycle.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No o_en is produced for the aborted request.
- Arithmetic:
  - Squares use 15×15 unsigned multiplies on magnitudes.
  - Magnitude of −32768 is handled after the vd clamp, so |vd_c| ≤ 32767.
  - No intermediate value exceeds 30 bits.

Test Plan:
- vd=3000, vq=4000, vmax=10000, i_en at edge N → o_en at edge N+17 only; o_vd=3000, o_vq=4000, o_limited=0; o_busy high for 17 cycles.
- vd=6000, vq=9000, vmax=10000 → rem=64,000,000, qlim=8000; o_vd=6000, o_vq=8000, o_limited=1.
- vd=1, vq=−5, vmax=3 (non-square rem=8) → qlim=2; o_vd=1, o_vq=−2, o_limited=1.
- Boundary: vd=−12000, vq=500, vmax=10000 → o_vd=−10000, o_vq=0. Then vd=−32768, vq=−32768, vmax=32767 → o_vd=−32767, o_vq=0, o_limited=1.
- i_en pulsed again at N+5 and N+17 with different data → ignored; exactly one o_en, carrying the first request's result. A request at N+18 is accepted; its o_en appears at N+35.
- rstn pulsed low at N+8 → all outputs 0 immediately; no o_en afterwards. A new request after release completes normally with 17-cycle latency.
